// File: rtl/dshot_input.sv
// DShot150 receiver: synchronizes the pin, measures high-pulse widths and assembles 16-bit
// frames into throttle, telemetry-request and special-command outputs.
module dshot_input #(
    parameter int unsigned BIT_THRESHOLD = 60,
    parameter int unsigned MIN_PULSE     = 8,
    parameter int unsigned FRAME_TIMEOUT = 200,
    parameter int unsigned CNT_W         = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inPin,
    output logic [10:0] setSpeed,
    output logic [5:0]  specialCommand,
    output logic        isSpecialCommand,
    output logic        CRCValid,
    output logic        processing,
    output logic        isValidSpeed,
    output logic        telemetryBit
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] HIGH = 2'd1;
    localparam logic [1:0] LOW  = 2'd2;

    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] THRESH_C   = CNT_W'(BIT_THRESHOLD);
    localparam logic [CNT_W-1:0] MIN_C      = CNT_W'(MIN_PULSE);
    localparam logic [CNT_W-1:0] TIMEOUT_C  = CNT_W'(FRAME_TIMEOUT - 1);

    logic [1:0]       sync_q, sync_d;
    logic [1:0]       state_q, state_d;
    logic             from_low_q, from_low_d;
    logic [CNT_W-1:0] hi_cnt_q, hi_cnt_d;
    logic [CNT_W-1:0] lo_cnt_q, lo_cnt_d;
    logic [3:0]       bit_idx_q, bit_idx_d;
    logic [15:0]      shift_q, shift_d;
    logic             done_q, done_d;
    logic             processing_q, processing_d;
    logic [10:0]      speed_q, speed_d;
    logic [5:0]       cmd_q, cmd_d;
    logic             special_q, special_d;
    logic             crc_valid_q, crc_valid_d;
    logic             valid_speed_q, valid_speed_d;
    logic             telem_q, telem_d;

    logic        rise, fall;
    logic [3:0]  crc;
    logic        crc_ok;
    logic [10:0] throttle;

    // Edges are taken as the synchronized level changes on its way into the second stage.
    assign rise = sync_q[0] & ~sync_q[1];
    assign fall = ~sync_q[0] & sync_q[1];

    assign crc      = shift_q[15:12] ^ shift_q[11:8] ^ shift_q[7:4];
    assign crc_ok   = (crc == shift_q[3:0]);
    assign throttle = shift_q[15:5];

    always_comb begin
        sync_d        = {sync_q[0], inPin};
        state_d       = state_q;
        from_low_d    = from_low_q;
        hi_cnt_d      = hi_cnt_q;
        lo_cnt_d      = lo_cnt_q;
        bit_idx_d     = bit_idx_q;
        shift_d       = shift_q;
        done_d        = 1'b0;
        processing_d  = processing_q;
        speed_d       = speed_q;
        cmd_d         = cmd_q;
        special_d     = special_q;
        crc_valid_d   = crc_valid_q;
        valid_speed_d = valid_speed_q;
        telem_d       = telem_q;

        if (done_q) begin
            state_d      = IDLE;
            processing_d = 1'b0;
            bit_idx_d    = 4'd0;
            crc_valid_d  = crc_ok;
            if (!crc_ok) begin
                valid_speed_d = 1'b0;
                special_d     = 1'b0;
            end else begin
                telem_d = shift_q[4];
                if (throttle >= 11'd48) begin
                    speed_d       = throttle;
                    valid_speed_d = 1'b1;
                    special_d     = 1'b0;
                end else begin
                    cmd_d         = throttle[5:0];
                    special_d     = 1'b1;
                    valid_speed_d = 1'b0;
                end
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (rise) begin
                        state_d      = HIGH;
                        hi_cnt_d     = '0;
                        from_low_d   = 1'b0;
                        processing_d = 1'b1;
                    end
                end
                HIGH: begin
                    if (fall) begin
                        if (hi_cnt_q < MIN_C) begin
                            // Glitch: resume whatever we were doing before the pulse.
                            state_d = from_low_q ? LOW : IDLE;
                            if (!from_low_q) processing_d = 1'b0;
                        end else begin
                            shift_d   = {shift_q[14:0], (hi_cnt_q >= THRESH_C)};
                            bit_idx_d = bit_idx_q + 4'd1;
                            done_d    = (bit_idx_q == 4'd15);
                            state_d   = LOW;
                            lo_cnt_d  = '0;
                        end
                    end else if (hi_cnt_q != CNT_MAX) begin
                        hi_cnt_d = hi_cnt_q + 1'b1;
                    end
                end
                LOW: begin
                    if (rise) begin
                        state_d    = HIGH;
                        hi_cnt_d   = '0;
                        from_low_d = 1'b1;
                    end else if (lo_cnt_q >= TIMEOUT_C) begin
                        state_d      = IDLE;
                        bit_idx_d    = 4'd0;
                        processing_d = 1'b0;
                    end else if (lo_cnt_q != CNT_MAX) begin
                        lo_cnt_d = lo_cnt_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q        <= '0;
            state_q       <= IDLE;
            from_low_q    <= 1'b0;
            hi_cnt_q      <= '0;
            lo_cnt_q      <= '0;
            bit_idx_q     <= '0;
            shift_q       <= '0;
            done_q        <= 1'b0;
            processing_q  <= 1'b0;
            speed_q       <= '0;
            cmd_q         <= '0;
            special_q     <= 1'b0;
            crc_valid_q   <= 1'b0;
            valid_speed_q <= 1'b0;
            telem_q       <= 1'b0;
        end else begin
            sync_q        <= sync_d;
            state_q       <= state_d;
            from_low_q    <= from_low_d;
            hi_cnt_q      <= hi_cnt_d;
            lo_cnt_q      <= lo_cnt_d;
            bit_idx_q     <= bit_idx_d;
            shift_q       <= shift_d;
            done_q        <= done_d;
            processing_q  <= processing_d;
            speed_q       <= speed_d;
            cmd_q         <= cmd_d;
            special_q     <= special_d;
            crc_valid_q   <= crc_valid_d;
            valid_speed_q <= valid_speed_d;
            telem_q       <= telem_d;
        end
    end

    assign setSpeed         = speed_q;
    assign specialCommand   = cmd_q;
    assign isSpecialCommand = special_q;
    assign CRCValid         = crc_valid_q;
    assign processing       = processing_q;
    assign isValidSpeed     = valid_speed_q;
    assign telemetryBit     = telem_q;

endmodule

// File: tb/tb_dshot_input.sv
// Bench for dshot_input: directed DShot150 frames plus randomized frames with jittered
// pulse widths, checked against a frame-level reference model.
module tb_dshot_input;

    logic        clk = 1'b0;
    logic        rst;
    logic        inPin;
    logic [10:0] setSpeed;
    logic [5:0]  specialCommand;
    logic        isSpecialCommand;
    logic        CRCValid;
    logic        processing;
    logic        isValidSpeed;
    logic        telemetryBit;

    int checks = 0;
    int errors = 0;

    // Reference state: what the outputs should show after the frames sent so far.
    int unsigned m_speed, m_cmd, m_special, m_crc, m_valid, m_tlm;

    dshot_input dut (
        .clk              (clk),
        .rst              (rst),
        .inPin            (inPin),
        .setSpeed         (setSpeed),
        .specialCommand   (specialCommand),
        .isSpecialCommand (isSpecialCommand),
        .CRCValid         (CRCValid),
        .processing       (processing),
        .isValidSpeed     (isValidSpeed),
        .telemetryBit     (telemetryBit)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic model_reset();
        m_speed = 0; m_cmd = 0; m_special = 0; m_crc = 0; m_valid = 0; m_tlm = 0;
    endtask

    function automatic logic [3:0] crc_of(input logic [11:0] v);
        int unsigned x;
        x = v;
        return 4'((x ^ (x >> 4) ^ (x >> 8)) & 32'hF);
    endfunction

    task automatic model_frame(input logic [15:0] f);
        int unsigned t;
        t = f >> 5;
        if (crc_of(f[15:4]) == f[3:0]) begin
            m_crc = 1;
            m_tlm = f[4];
            if (t >= 48) begin
                m_speed = t; m_valid = 1; m_special = 0;
            end else begin
                m_cmd = t % 64; m_special = 1; m_valid = 0;
            end
        end else begin
            m_crc = 0; m_valid = 0; m_special = 0;
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_speed"},   32'(setSpeed),         m_speed);
        check({tag, "_cmd"},     32'(specialCommand),   m_cmd);
        check({tag, "_special"}, 32'(isSpecialCommand), m_special);
        check({tag, "_crc"},     32'(CRCValid),         m_crc);
        check({tag, "_valid"},   32'(isValidSpeed),     m_valid);
        check({tag, "_tlm"},     32'(telemetryBit),     m_tlm);
    endtask

    // One DShot150 bit (~107 clk) with jittered high time; optional 3-clk glitch in the low part.
    task automatic send_bit(input logic b, input bit glitch);
        int hi, lo;
        hi = b ? int'($urandom_range(72, 88)) : int'($urandom_range(32, 48));
        lo = 107 - hi;
        inPin = 1'b1;
        tick(hi);
        inPin = 1'b0;
        if (glitch) begin
            tick(8);
            inPin = 1'b1;
            tick(3);
            inPin = 1'b0;
            tick(lo - 11);
        end else begin
            tick(lo);
        end
    endtask

    // Full frame; the last bit checks completion latency and the decoded outputs.
    task automatic send_frame(input logic [15:0] f, input int glitch_bit, input string tag);
        int hi;
        for (int i = 15; i > 0; i--) send_bit(f[i], i == glitch_bit);
        hi = f[0] ? int'($urandom_range(72, 88)) : int'($urandom_range(32, 48));
        inPin = 1'b1;
        tick(hi);
        inPin = 1'b0;
        tick(2);
        check({tag, "_busy"}, 32'(processing), 1);
        tick(1);
        check({tag, "_idle"}, 32'(processing), 0);
        model_frame(f);
        check_outputs(tag);
        tick(107 - hi - 3);
    endtask

    initial begin
        logic [15:0] f;
        logic [11:0] v;
        model_reset();
        rst   = 1'b1;
        inPin = 1'b0;
        tick(5);
        rst = 1'b0;
        tick(2);
        check_outputs("reset");
        check("reset_proc", 32'(processing), 0);

        send_frame(16'hDEA9, -1, "dea9");
        check("dea9_speed_lit", 32'(setSpeed), 1781);
        check("dea9_valid_lit", 32'(isValidSpeed), 1);

        send_frame(16'h0033, -1, "cmd1");
        check("cmd1_lit", 32'(specialCommand), 1);
        check("cmd1_hold_lit", 32'(setSpeed), 1781);

        send_frame(16'hDEA9, -1, "dea9b");
        send_frame(16'hDEA8, -1, "badcrc");
        check("badcrc_lit", 32'(CRCValid), 0);
        check("badcrc_hold_lit", 32'(setSpeed), 1781);

        // Partial frame abandoned by timeout.
        send_frame(16'h0033, -1, "pre_to");
        for (int i = 15; i >= 8; i--) send_bit(1'(16'hDEA9 >> i), 1'b0);
        check("partial_busy", 32'(processing), 1);
        tick(250);
        check("timeout_proc", 32'(processing), 0);
        check_outputs("timeout");
        send_frame(16'hDEA9, -1, "after_to");
        check("after_to_lit", 32'(setSpeed), 1781);

        // Glitch during the low part of a '0' bit (bit 11 of DEA9 is 1, bit 8 is 0).
        send_frame(16'h0033, -1, "pre_gl");
        send_frame(16'hDEA9, 8, "glitch");
        check("glitch_lit", 32'(setSpeed), 1781);

        // Reset in the middle of a frame.
        for (int i = 15; i > 10; i--) send_bit(1'(16'hDEA9 >> i), 1'b0);
        inPin = 1'b1;
        tick(20);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        model_reset();
        check_outputs("midrst");
        tick(50);
        inPin = 1'b0;
        tick(30);
        for (int i = 9; i >= 0; i--) send_bit(1'(16'hDEA9 >> i), 1'b0);
        tick(250);
        check_outputs("midrst_late");
        check("midrst_proc", 32'(processing), 0);
        send_frame(16'h0000, -1, "zero");
        check("zero_special_lit", 32'(isSpecialCommand), 1);

        // Randomized frames: mix of speeds, special commands and corrupted CRCs.
        for (int n = 0; n < 14; n++) begin
            v = 12'($urandom);
            if ($urandom_range(0, 3) == 0) v[11:1] = 11'($urandom_range(0, 47));
            f = {v, crc_of(v)};
            if ($urandom_range(0, 3) == 0) f[3:0] = f[3:0] ^ 4'($urandom_range(1, 15));
            send_frame(f, ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 15)) : -1, "rand");
            tick(int'($urandom_range(0, 300)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
